fwd_hazard_ctrl: RTL and testbench

//  Forwarding and load-use hazard controller for the 5-stage core. It generates the EX-stage

---
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding select and load-use stall control for the 5-stage core.
// rd1/rd2_ctr and ex_bubble register on the ID->EX transfer; stall is combinational and holds PC and IF/ID.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [1:0]            rd1_ctr,
  output logic [1:0]            rd2_ctr,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_we;
  logic                  r_ex_load;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_we;

  logic                  r_ex_bubble;
  logic [1:0]            r_rd1_ctr;
  logic [1:0]            r_rd2_ctr;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic                  w_rs1_ex_match;
  logic                  w_rs2_ex_match;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_kill;
  logic [1:0]            w_rd1_nxt;
  logic [1:0]            w_rd2_nxt;

  // WB producers need no tracking: the regfile is write-first, so ID already reads them.
  function automatic logic [1:0] fwd_sel(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  ex_we,
    input logic                  ex_load,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  mem_we,
    input logic [REG_ADDR_W-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (rs != '0)) begin
      if (ex_we && !ex_load && (rs == ex_rd)) begin
        sel = 2'b01;
      end else if (mem_we && (rs == mem_rd)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  assign w_rs1_ex_match = id_rs1_used && (id_rs1 == r_ex_rd);
  assign w_rs2_ex_match = id_rs2_used && (id_rs2 == r_ex_rd);
  assign w_hazard = id_valid && r_ex_we && r_ex_load && (r_ex_rd != '0) &&
                    (w_rs1_ex_match || w_rs2_ex_match);
  assign w_stall  = w_hazard && !ex_flush && (r_state == RUN);
  assign w_kill   = w_stall || ex_flush;

  assign w_rd1_nxt = fwd_sel(id_rs1_used, id_rs1, r_ex_we, r_ex_load, r_ex_rd, r_mem_we, r_mem_rd);
  assign w_rd2_nxt = fwd_sel(id_rs2_used, id_rs2, r_ex_we, r_ex_load, r_ex_rd, r_mem_we, r_mem_rd);

  // One stall cycle is enough: the load reaches MEM and the consumer then takes it via 11.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_stall) w_state_nxt = STALL;
      STALL:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rd     <= '0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_we    <= 1'b0;
      r_ex_bubble <= 1'b1;
      r_rd1_ctr   <= 2'b00;
      r_rd2_ctr   <= 2'b00;
      r_stall_cnt <= '0;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_we <= r_ex_we;
      if (w_kill) begin
        r_ex_rd     <= '0;
        r_ex_we     <= 1'b0;
        r_ex_load   <= 1'b0;
        r_ex_bubble <= 1'b1;
        r_rd1_ctr   <= 2'b00;
        r_rd2_ctr   <= 2'b00;
      end else begin
        r_ex_rd     <= id_rd;
        r_ex_we     <= id_valid && id_reg_write;
        r_ex_load   <= id_valid && id_is_load;
        r_ex_bubble <= !id_valid;
        r_rd1_ctr   <= w_rd1_nxt;
        r_rd2_ctr   <= w_rd2_nxt;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall     = w_stall;
  assign ex_bubble = r_ex_bubble;
  assign rd1_ctr   = r_rd1_ctr;
  assign rd2_ctr   = r_rd2_ctr;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: per-scenario tasks, expected EX-stage outputs queued at issue time.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
  } ins_t;

  typedef struct packed {
    logic       bub;
    logic [1:0] c1;
    logic [1:0] c2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_is_load = 1'b0;
  logic       ex_flush = 1'b0;
  logic       stall;
  logic       ex_bubble;
  logic [1:0] rd1_ctr;
  logic [1:0] rd2_ctr;
  logic [1:0] stall_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  ins_t p_ins[$];
  logic p_st[$];
  exp_t p_exp[$];
  logic exp_st;
  exp_t got;
  exp_t exp_v;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_flush(ex_flush),
    .stall(stall), .ex_bubble(ex_bubble), .rd1_ctr(rd1_ctr), .rd2_ctr(rd2_ctr),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ins_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, we: 1'b1, ld: 1'b0, fl: 1'b0};
    return i;
  endfunction

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, we: 1'b1, ld: 1'b1, fl: 1'b0};
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    i.v = 1'b1;
    return i;
  endfunction

  task automatic apply(input ins_t i);
    id_valid     = i.v;
    id_rs1       = i.rs1;
    id_rs2       = i.rs2;
    id_rs1_used  = i.u1;
    id_rs2_used  = i.u2;
    id_rd        = i.rd;
    id_reg_write = i.we;
    id_is_load   = i.ld;
    ex_flush     = i.fl;
  endtask

  task automatic plan(input ins_t i, input logic st, input logic bub, input logic [1:0] c1,
                      input logic [1:0] c2);
    exp_t e;
    e = '{bub: bub, c1: c1, c2: c2};
    p_ins.push_back(i);
    p_st.push_back(st);
    p_exp.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt} !== 7'b0_1_00_00_00) begin
      n_errors++;
      $display("FAIL reset_values: got stall=%b bub=%b c1=%b c2=%b cnt=%0d, expected 0 1 00 00 0",
               stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fwd_ex();
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd5, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd6, 5'd5, 5'd1), 0, 0, 2'b01, 2'b00);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL fwd_ex stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL fwd_ex ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
  endtask

  task automatic test_fwd_mem();
    ins_t inv;
    inv = '0;
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd5, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd7, 5'd1, 5'd5), 0, 0, 2'b00, 2'b11);
    plan(alu(5'd5, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd10, 5'd5, 5'd5), 0, 0, 2'b00, 2'b00);
    plan(inv, 0, 1, 2'b00, 2'b00);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL fwd_mem stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL fwd_mem ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
  endtask

  task automatic test_x0();
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd0, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd3, 5'd0, 5'd0), 0, 0, 2'b00, 2'b00);
    plan(lw(5'd0, 5'd1), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd4, 5'd0, 5'd0), 0, 0, 2'b00, 2'b00);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL x0 stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL x0 ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
  endtask

  task automatic test_back_to_back();
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd3, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd3, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd11, 5'd3, 5'd3), 0, 0, 2'b01, 2'b01);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL back_to_back stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL back_to_back ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
  endtask

  task automatic test_load_use();
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(lw(5'd8, 5'd1), 0, 0, 2'b00, 2'b00);
    plan(alu(5'd9, 5'd8, 5'd8), 1, 1, 2'b00, 2'b00);
    plan(alu(5'd9, 5'd8, 5'd8), 0, 0, 2'b11, 2'b11);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL load_use stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL load_use ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
    n_checks++;
    if (stall_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL load_use stall_cnt: got %0d, expected 1", stall_cnt);
    end
  endtask

  task automatic test_flush();
    ins_t fi;
    fi = alu(5'd9, 5'd8, 5'd8);
    fi.fl = 1'b1;
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    plan(lw(5'd8, 5'd1), 0, 0, 2'b00, 2'b00);
    plan(fi, 0, 1, 2'b00, 2'b00);
    plan(nop(), 0, 0, 2'b00, 2'b00);
    while (p_ins.size() != 0) begin
      apply(p_ins.pop_front());
      sb.push_back(p_exp.pop_front());
      exp_st = p_st.pop_front();
      @(negedge clk);
      n_checks++;
      if (stall !== exp_st) begin
        n_errors++;
        $display("FAIL flush stall: got %b, expected %b", stall, exp_st);
      end
      @(posedge clk);
      #1;
      got = {ex_bubble, rd1_ctr, rd2_ctr};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL flush ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                 got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
      end
    end
    n_checks++;
    if (stall_cnt !== 2'd1) begin
      n_errors++;
      $display("FAIL flush stall_cnt: got %0d, expected 1", stall_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    for (int k = 0; k < 4; k++) begin
      exp_cnt = (k >= 1) ? 2'd3 : 2'd2;
      plan(lw(5'd8, 5'd1), 0, 0, 2'b00, 2'b00);
      plan(alu(5'd9, 5'd8, 5'd8), 1, 1, 2'b00, 2'b00);
      plan(alu(5'd9, 5'd8, 5'd8), 0, 0, 2'b11, 2'b11);
      while (p_ins.size() != 0) begin
        apply(p_ins.pop_front());
        sb.push_back(p_exp.pop_front());
        exp_st = p_st.pop_front();
        @(negedge clk);
        n_checks++;
        if (stall !== exp_st) begin
          n_errors++;
          $display("FAIL saturate stall: got %b, expected %b", stall, exp_st);
        end
        @(posedge clk);
        #1;
        got = {ex_bubble, rd1_ctr, rd2_ctr};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) begin
          n_errors++;
          $display("FAIL saturate ex_out: got bub=%b c1=%b c2=%b, expected bub=%b c1=%b c2=%b",
                   got.bub, got.c1, got.c2, exp_v.bub, exp_v.c1, exp_v.c2);
        end
      end
      n_checks++;
      if (stall_cnt !== exp_cnt) begin
        n_errors++;
        $display("FAIL saturate stall_cnt iter %0d: got %0d, expected %0d", k, stall_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    apply(nop());
    @(posedge clk);
    #1;
    apply(lw(5'd8, 5'd1));
    @(posedge clk);
    #1;
    apply(alu(5'd9, 5'd8, 5'd8));
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_hazard pre_stall: got %b, expected 1", stall);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt} !== 7'b0_1_00_00_00) begin
      n_errors++;
      $display("FAIL rst_hazard async: got stall=%b bub=%b c1=%b c2=%b cnt=%0d, expected 0 1 00 00 0",
               stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    apply(lw(5'd8, 5'd1));
    @(posedge clk);
    #1;
    apply(alu(5'd9, 5'd8, 5'd8));
    @(posedge clk);
    #1;
    n_checks++;
    if (stall_cnt !== 2'd1 || ex_bubble !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_stall entered: got cnt=%0d bub=%b, expected 1 1", stall_cnt, ex_bubble);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt} !== 7'b0_1_00_00_00) begin
      n_errors++;
      $display("FAIL rst_stall async: got stall=%b bub=%b c1=%b c2=%b cnt=%0d, expected 0 1 00 00 0",
               stall, ex_bubble, rd1_ctr, rd2_ctr, stall_cnt);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ex_bubble, rd1_ctr, rd2_ctr} !== 5'b0_00_00) begin
      n_errors++;
      $display("FAIL rst_stall after: got bub=%b c1=%b c2=%b, expected 0 00 00",
               ex_bubble, rd1_ctr, rd2_ctr);
    end
    apply(lw(5'd8, 5'd1));
    @(posedge clk);
    #1;
    apply(alu(5'd9, 5'd8, 5'd8));
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_stall fsm_run: got stall=%b, expected 1", stall);
    end
    @(posedge clk);
    #1;
    apply(nop());
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_x0();
    test_back_to_back();
    test_load_use();
    test_flush();
    test_saturate();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
